// File: rtl/vram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vram_arb_pkg
// Shared constants and types for the VRAM arbiter slice.
//   AW / DW / DEPTH : address width, pixel width, number of valid locations
//   VID_LAT         : cycles from vid_req to vid_valid
//   owner_t         : owner of an issued RAM cycle
//   slot_t          : per-cycle pipeline record (owner, read flag, out-of-range)
//   cpu_state_t     : CPU port FSM encoding
//   fill_state_t    : fill engine FSM encoding
// Optional feature macro used by the slice: VRAM_ARB_FILL_EN
// -----------------------------------------------------------------------------
package vram_arb_pkg;

  localparam int AW      = 14;
  localparam int DW      = 8;
  localparam int DEPTH   = 16000;
  localparam int VID_LAT = 3;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_FILL = 2'd2,
    OWN_CPU  = 2'd3
  } owner_t;

  typedef struct packed {
    owner_t own;
    logic   rd;   // cycle is a read whose data must be returned
    logic   oor;  // address was out of range: return 0x00
  } slot_t;

  localparam slot_t SLOT_NONE = '{own: OWN_NONE, rd: 1'b0, oor: 1'b0};

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_RD1  = 2'd1,
    C_RD2  = 2'd2
  } cpu_state_t;

  typedef enum logic {
    F_IDLE = 1'b0,
    F_RUN  = 1'b1
  } fill_state_t;

  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// -----------------------------------------------------------------------------
// vram_arbiter_if
// Bundles the three requester ports, the RAM port and FSM debug state.
//   slave  : arbiter side (requests/ram_rdata in; responses/RAM controls out)
//   master : environment side (video fetch, CPU, fill trigger and the RAM)
// Handshakes:
//   vid_req is a one-cycle strobe answered by a one-cycle vid_valid exactly
//   VID_LAT cycles later; cpu_req is a level held (with stable we/addr/wdata)
//   until the one-cycle cpu_ack; fill_start is a one-cycle trigger that is
//   accepted only while fill_busy is low.
// -----------------------------------------------------------------------------
interface vram_arbiter_if #(
  parameter int AW = vram_arb_pkg::AW,
  parameter int DW = vram_arb_pkg::DW
);
  import vram_arb_pkg::*;

  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic          vid_valid;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          fill_start;
  logic [DW-1:0] fill_color;
  logic          fill_busy;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  cpu_state_t    dbg_cpu_state;
  fill_state_t   dbg_fill_state;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           fill_start, fill_color, ram_rdata,
    output vid_data, vid_valid, cpu_ack, cpu_rdata, fill_busy,
           ram_addr, ram_we, ram_wdata, dbg_cpu_state, dbg_fill_state
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           fill_start, fill_color, ram_rdata,
    input  vid_data, vid_valid, cpu_ack, cpu_rdata, fill_busy,
           ram_addr, ram_we, ram_wdata, dbg_cpu_state, dbg_fill_state
  );

endinterface

// File: rtl/vram_fill_engine.sv
// -----------------------------------------------------------------------------
// vram_fill_engine
// Writes one colour to every location 0..DEPTH-1, one write per free slot.
// Only instantiated when VRAM_ARB_FILL_EN is defined.
// Ports:
//   clk, reset    : pixel clock, synchronous active-high reset
//   i_start       : one-cycle trigger, accepted in F_IDLE only
//   i_color       : fill colour, latched on an accepted i_start
//   i_slot_free   : the RAM slot this cycle is not taken by video
//   o_wr_req      : fill owns the slot this cycle
//   o_addr/o_data : write address/data for that slot
//   o_busy        : fill in progress
//   o_state       : FSM state (debug)
// -----------------------------------------------------------------------------
module vram_fill_engine
  import vram_arb_pkg::*;
#(
  parameter int AW    = vram_arb_pkg::AW,
  parameter int DW    = vram_arb_pkg::DW,
  parameter int DEPTH = vram_arb_pkg::DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_start,
  input  logic [DW-1:0] i_color,
  input  logic          i_slot_free,
  output logic          o_wr_req,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic          o_busy,
  output fill_state_t   o_state
);

  fill_state_t   r_state, w_state_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;
  logic [DW-1:0] r_color, w_color_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= F_IDLE;
      r_cnt   <= '0;
      r_color <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_color <= w_color_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_color_nxt = r_color;
    unique case (r_state)
      F_IDLE: begin
        if (i_start) begin
          w_state_nxt = F_RUN;
          w_cnt_nxt   = '0;
          w_color_nxt = i_color;
        end
      end
      F_RUN: begin
        // Advance only on slots video did not take; the last write ends the run.
        if (i_slot_free) begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == AW'(DEPTH - 1)) w_state_nxt = F_IDLE;
        end
      end
      default: w_state_nxt = F_IDLE;
    endcase
  end

  assign o_wr_req = (r_state == F_RUN) && i_slot_free;
  assign o_addr   = r_cnt;
  assign o_data   = r_color;
  assign o_busy   = (r_state == F_RUN);
  assign o_state  = r_state;

endmodule

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Shares one synchronous single-port VRAM between video scanout, a CPU port
// and an optional fill engine. Fixed priority video > fill > CPU, one grant
// per cycle. RAM controls are registered; ram_rdata returns one cycle after
// ram_addr and is steered back using a VID_LAT-1 deep owner pipeline.
// Ports:
//   pclk  : pixel clock
//   reset : synchronous active-high reset
//   bus   : vram_arbiter_if.slave (video, CPU, fill, RAM, debug state)
// Macro: VRAM_ARB_FILL_EN adds the fill engine; without it fill_start and
//   fill_color are ignored, fill_busy is 0 and priority is video > CPU.
// -----------------------------------------------------------------------------
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int AW    = vram_arb_pkg::AW,
  parameter int DW    = vram_arb_pkg::DW,
  parameter int DEPTH = vram_arb_pkg::DEPTH
) (
  input  logic           pclk,
  input  logic           reset,
  vram_arbiter_if.slave  bus
);

  localparam int PIPE = VID_LAT - 1;  // RAM address stage + RAM data stage

  // Fill engine hookup
  logic          w_fill_req;
  logic [AW-1:0] w_fill_addr;
  logic [DW-1:0] w_fill_data;
  logic          w_fill_busy;
  fill_state_t   w_fill_state;

`ifdef VRAM_ARB_FILL_EN
  vram_fill_engine #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fill (
    .clk         (pclk),
    .reset       (reset),
    .i_start     (bus.fill_start),
    .i_color     (bus.fill_color),
    .i_slot_free (!bus.vid_req),
    .o_wr_req    (w_fill_req),
    .o_addr      (w_fill_addr),
    .o_data      (w_fill_data),
    .o_busy      (w_fill_busy),
    .o_state     (w_fill_state)
  );
`else
  logic w_unused_fill;
  assign w_unused_fill = ^{bus.fill_start, bus.fill_color};
  assign w_fill_req    = 1'b0;
  assign w_fill_addr   = '0;
  assign w_fill_data   = '0;
  assign w_fill_busy   = 1'b0;
  assign w_fill_state  = F_IDLE;
`endif

  // Registers
  logic [AW-1:0] r_ram_addr;
  logic          r_ram_we;
  logic [DW-1:0] r_ram_wdata;
  logic [DW-1:0] r_vid_data;
  logic          r_vid_valid;
  logic          r_cpu_ack;
  logic [DW-1:0] r_cpu_rdata;
  cpu_state_t    r_cpu_state, w_cpu_state_nxt;
  slot_t         r_pipe [PIPE];

  // Grant decision
  slot_t         w_slot;
  logic [AW-1:0] w_addr;
  logic          w_we;
  logic [DW-1:0] w_wdata;
  logic          w_cpu_grant;
  logic          w_cpu_can;
  logic          w_vid_ok;
  logic          w_cpu_ok;

  assign w_vid_ok = addr_in_range(32'(bus.vid_addr), DEPTH);
  assign w_cpu_ok = addr_in_range(32'(bus.cpu_addr), DEPTH);

  // No CPU grant while a read is in flight, in the cycle of an ack (so the
  // still-high cpu_req is not taken twice), or while a fill is running.
  assign w_cpu_can = bus.cpu_req && (r_cpu_state == C_IDLE) && !r_cpu_ack &&
                     !w_fill_busy;

  always_comb begin
    w_slot      = SLOT_NONE;
    w_addr      = r_ram_addr;
    w_we        = 1'b0;
    w_wdata     = r_ram_wdata;
    w_cpu_grant = 1'b0;
    if (bus.vid_req) begin
      w_slot = '{own: OWN_VID, rd: 1'b1, oor: !w_vid_ok};
      w_addr = bus.vid_addr;
    end else if (w_fill_req) begin
      w_slot  = '{own: OWN_FILL, rd: 1'b0, oor: 1'b0};
      w_addr  = w_fill_addr;
      w_we    = 1'b1;
      w_wdata = w_fill_data;
    end else if (w_cpu_can) begin
      w_cpu_grant = 1'b1;
      w_slot      = '{own: OWN_CPU, rd: !bus.cpu_we, oor: !w_cpu_ok};
      w_addr      = bus.cpu_addr;
      // Out-of-range writes are acknowledged but never reach the RAM.
      w_we        = bus.cpu_we && w_cpu_ok;
      if (bus.cpu_we) w_wdata = bus.cpu_wdata;
    end
  end

  // Read return steering from the tail of the owner pipeline
  slot_t         w_tail;
  logic          w_vid_ret;
  logic          w_cpu_ret;
  logic [DW-1:0] w_ret_data;

  assign w_tail     = r_pipe[PIPE-1];
  assign w_vid_ret  = (w_tail.own == OWN_VID);
  assign w_cpu_ret  = (w_tail.own == OWN_CPU) && w_tail.rd;
  assign w_ret_data = w_tail.oor ? '0 : bus.ram_rdata;

  // CPU FSM next state
  always_comb begin
    w_cpu_state_nxt = r_cpu_state;
    unique case (r_cpu_state)
      C_IDLE:  if (w_cpu_grant && !bus.cpu_we) w_cpu_state_nxt = C_RD1;
      C_RD1:   w_cpu_state_nxt = C_RD2;
      C_RD2:   w_cpu_state_nxt = C_IDLE;
      default: w_cpu_state_nxt = C_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
      r_vid_data  <= '0;
      r_vid_valid <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_cpu_state <= C_IDLE;
      for (int i = 0; i < PIPE; i++) r_pipe[i] <= SLOT_NONE;
    end else begin
      r_ram_addr  <= w_addr;
      r_ram_we    <= w_we;
      r_ram_wdata <= w_wdata;
      r_pipe[0]   <= w_slot;
      for (int i = 1; i < PIPE; i++) r_pipe[i] <= r_pipe[i-1];
      r_vid_valid <= w_vid_ret;
      if (w_vid_ret) r_vid_data <= w_ret_data;
      // Writes ack together with ram_we; reads ack when their data returns.
      r_cpu_ack   <= (w_cpu_grant && bus.cpu_we) || w_cpu_ret;
      if (w_cpu_ret) r_cpu_rdata <= w_ret_data;
      r_cpu_state <= w_cpu_state_nxt;
    end
  end

  assign bus.ram_addr       = r_ram_addr;
  assign bus.ram_we         = r_ram_we;
  assign bus.ram_wdata      = r_ram_wdata;
  assign bus.vid_data       = r_vid_data;
  assign bus.vid_valid      = r_vid_valid;
  assign bus.cpu_ack        = r_cpu_ack;
  assign bus.cpu_rdata      = r_cpu_rdata;
  assign bus.fill_busy      = w_fill_busy;
  assign bus.dbg_cpu_state  = r_cpu_state;
  assign bus.dbg_fill_state = w_fill_state;

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
// Directed bench for vram_arbiter with a behavioural synchronous RAM.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// Define VRAM_ARB_FILL_EN to exercise the fill engine.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;
  import vram_arb_pkg::*;

  logic pclk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  vram_arbiter_if bus ();

  vram_arbiter dut (
    .pclk  (pclk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset block
  always #5 pclk = ~pclk;

  // behavioural RAM: write-first not needed, read returns old contents
  logic [7:0] mem [0:16383];
  always @(posedge pclk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.vid_req    = 1'b0;
    bus.vid_addr   = '0;
    bus.cpu_req    = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
    bus.fill_start = 1'b0;
    bus.fill_color = '0;
  endtask

  task automatic cpu_drive(input logic we, input logic [13:0] addr,
                           input logic [7:0] wdata);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
  endtask

  logic [31:0] all_outs;
  assign all_outs = {bus.ram_addr, bus.ram_we, bus.ram_wdata, bus.vid_data,
                     bus.vid_valid, bus.cpu_ack, bus.cpu_rdata, bus.fill_busy};

  initial begin
    int acks;
    int we_seen;
    int busy_cycles;
    int stolen;
    int early_ack;
    int cyc;
    int bad;
    int ack_seen;

    for (int i = 0; i < 16384; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[16]    = 8'hA5;
    mem[16000] = 8'h77;
    mem[16001] = 8'h66;

    // ---------------- reset ----------------
    idle_inputs();
    bus.ram_rdata = '0;
    reset = 1'b1;
    tick();
    tick();
    check("reset_outputs", all_outs, 32'h0);
    check("reset_cpu_state", 32'(bus.dbg_cpu_state), 32'(C_IDLE));
    check("reset_fill_state", 32'(bus.dbg_fill_state), 32'(F_IDLE));
    reset = 1'b0;
    tick();

    // ---------------- video fetch, every 4 cycles ----------------
    for (int n = 0; n < 3; n++) begin
      bus.vid_req  = 1'b1;
      bus.vid_addr = 14'h0010;
      tick();                                   // cycle 1
      bus.vid_req = 1'b0;
      check("vid_c1_addr", 32'(bus.ram_addr), 32'h10);
      check("vid_c1_we", 32'(bus.ram_we), 32'h0);
      check("vid_c1_valid", 32'(bus.vid_valid), 32'h0);
      tick();                                   // cycle 2
      check("vid_c2_valid", 32'(bus.vid_valid), 32'h0);
      tick();                                   // cycle 3
      check("vid_c3_valid", 32'(bus.vid_valid), 32'h1);
      check("vid_c3_data", 32'(bus.vid_data), 32'hA5);
      tick();                                   // cycle 4
      check("vid_c4_valid", 32'(bus.vid_valid), 32'h0);
    end

    // ---------------- CPU write then read ----------------
    cpu_drive(1'b1, 14'd100, 8'h3C);
    tick();                                     // cycle 1
    check("wr_c1_ack", 32'(bus.cpu_ack), 32'h1);
    check("wr_c1_we", 32'(bus.ram_we), 32'h1);
    check("wr_c1_addr", 32'(bus.ram_addr), 32'd100);
    check("wr_c1_wdata", 32'(bus.ram_wdata), 32'h3C);
    bus.cpu_req = 1'b0;
    tick();
    check("wr_c2_ack", 32'(bus.cpu_ack), 32'h0);
    check("wr_c2_we", 32'(bus.ram_we), 32'h0);

    cpu_drive(1'b0, 14'd100, 8'h00);
    tick();                                     // cycle 1
    check("rd_c1_ack", 32'(bus.cpu_ack), 32'h0);
    check("rd_c1_addr", 32'(bus.ram_addr), 32'd100);
    check("rd_c1_state", 32'(bus.dbg_cpu_state), 32'(C_RD1));
    tick();                                     // cycle 2
    check("rd_c2_ack", 32'(bus.cpu_ack), 32'h0);
    tick();                                     // cycle 3
    check("rd_c3_ack", 32'(bus.cpu_ack), 32'h1);
    check("rd_c3_data", 32'(bus.cpu_rdata), 32'h3C);
    bus.cpu_req = 1'b0;
    tick();
    check("rd_c4_ack", 32'(bus.cpu_ack), 32'h0);

    // ---------------- contention: video and CPU read together ----------------
    bus.vid_req  = 1'b1;
    bus.vid_addr = 14'h0010;
    cpu_drive(1'b0, 14'd100, 8'h00);
    tick();                                     // cycle 1
    bus.vid_req = 1'b0;
    check("con_c1_vid_first", 32'(bus.ram_addr), 32'h10);
    tick();                                     // cycle 2
    check("con_c2_cpu_addr", 32'(bus.ram_addr), 32'd100);
    check("con_c2_ack", 32'(bus.cpu_ack), 32'h0);
    tick();                                     // cycle 3
    check("con_c3_vid_valid", 32'(bus.vid_valid), 32'h1);
    check("con_c3_vid_data", 32'(bus.vid_data), 32'hA5);
    check("con_c3_ack", 32'(bus.cpu_ack), 32'h0);
    tick();                                     // cycle 4
    check("con_c4_ack", 32'(bus.cpu_ack), 32'h1);
    check("con_c4_data", 32'(bus.cpu_rdata), 32'h3C);
    bus.cpu_req = 1'b0;
    tick();

    // ---------------- out-of-range ----------------
    cpu_drive(1'b1, 14'd16000, 8'hFF);
    tick();
    check("oor_wr_ack", 32'(bus.cpu_ack), 32'h1);
    check("oor_wr_we", 32'(bus.ram_we), 32'h0);
    bus.cpu_req = 1'b0;
    tick();
    check("oor_wr_we_after", 32'(bus.ram_we), 32'h0);
    check("oor_wr_mem", 32'(mem[16000]), 32'h77);

    cpu_drive(1'b0, 14'd16000, 8'h00);
    tick();
    tick();
    tick();
    check("oor_rd_ack", 32'(bus.cpu_ack), 32'h1);
    check("oor_rd_data", 32'(bus.cpu_rdata), 32'h00);
    bus.cpu_req = 1'b0;
    tick();

    bus.vid_req  = 1'b1;
    bus.vid_addr = 14'd16001;
    tick();
    bus.vid_req = 1'b0;
    tick();
    tick();
    check("oor_vid_valid", 32'(bus.vid_valid), 32'h1);
    check("oor_vid_data", 32'(bus.vid_data), 32'h00);
    tick();

    // ---------------- reset during C_RD1 ----------------
    cpu_drive(1'b0, 14'd16, 8'h00);
    tick();
    check("rst_rd1_state", 32'(bus.dbg_cpu_state), 32'(C_RD1));
    reset       = 1'b1;
    bus.cpu_req = 1'b0;
    tick();
    check("rst_rd1_outputs", all_outs, 32'h0);
    check("rst_rd1_idle", 32'(bus.dbg_cpu_state), 32'(C_IDLE));
    reset = 1'b0;
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.cpu_ack) acks++;
    end
    check("rst_rd1_no_ack", 32'(acks), 32'd0);

`ifdef VRAM_ARB_FILL_EN
    // ---------------- fill with concurrent video and CPU write ----------------
    bus.fill_start = 1'b1;
    bus.fill_color = 8'hE0;
    bus.vid_req    = 1'b1;
    bus.vid_addr   = 14'h0010;
    tick();
    bus.fill_start = 1'b0;
    bus.vid_req    = 1'b0;
    check("fill_busy_rise", 32'(bus.fill_busy), 32'h1);
    busy_cycles = 0;
    stolen      = 0;
    early_ack   = 0;
    cyc         = 1;
    while (bus.fill_busy && cyc < 40000) begin
      bus.vid_req = (cyc % 4 == 0);
      if (cyc == 10) cpu_drive(1'b1, 14'd200, 8'h11);
      busy_cycles++;
      if (bus.vid_req) stolen++;
      tick();
      if (bus.cpu_ack && bus.fill_busy) early_ack++;
      cyc++;
    end
    bus.vid_req = 1'b0;
    check("fill_ended", 32'(bus.fill_busy), 32'h0);
    check("fill_duration", 32'(busy_cycles), 32'(DEPTH + stolen));
    check("fill_no_cpu_ack", 32'(early_ack), 32'd0);
    ack_seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.cpu_ack) ack_seen = 1;
      if (ack_seen == 0) tick();
    end
    check("fill_cpu_ack_after", 32'(ack_seen), 32'd1);
    bus.cpu_req = 1'b0;
    tick();
    tick();
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] !== ((i == 200) ? 8'h11 : 8'hE0)) bad++;
    end
    check("fill_contents", 32'(bad), 32'd0);
    check("fill_oor_untouched", 32'(mem[16000]), 32'h77);
`else
    // ---------------- fill disabled: trigger must be ignored ----------------
    bus.fill_start = 1'b1;
    bus.fill_color = 8'hE0;
    tick();
    bus.fill_start = 1'b0;
    busy_cycles = 0;
    we_seen     = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.fill_busy) busy_cycles++;
      if (bus.ram_we) we_seen++;
      tick();
    end
    check("nofill_busy", 32'(busy_cycles), 32'd0);
    check("nofill_writes", 32'(we_seen), 32'd0);
    check("nofill_state", 32'(bus.dbg_fill_state), 32'(F_IDLE));
    check("nofill_mem0", 32'(mem[0]), 32'h5A);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
